// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller for the pipelined LC-3b: sequences LDR/STR/LDB/STB
// and indirect LDI/STI against a resp-handshaked dmem. Optional stall counter: MEM_STALL_CNT_EN.
module mem_access_ctrl #(
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_byte,
  input  logic        mem_indirect,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        mem_stall,
  output logic [15:0] mem_rdata_out,
  output logic        mem_done
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, PTR, FINAL, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        byte_q, byte_d;
  logic        write_q, write_d;
  logic        ind_q, ind_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic [15:0] dmem_address_q, dmem_address_d;
  logic [15:0] dmem_wdata_q, dmem_wdata_d;
  logic        dmem_read_q, dmem_read_d;
  logic        dmem_write_q, dmem_write_d;
  logic [1:0]  dmem_be_q, dmem_be_d;
  logic [15:0] fin_addr_cur_s;
  logic [15:0] fin_addr_nxt_s;

  function automatic logic [15:0] format_load(input logic is_byte, input logic a0,
                                              input logic [15:0] d);
    logic [15:0] r;
    if (!is_byte) begin
      r = d;
    end else if (a0) begin
      r = {8'h00, d[15:8]};
    end else begin
      r = {8'h00, d[7:0]};
    end
    return r;
  endfunction

  function automatic logic [1:0] lane_enable(input logic is_byte, input logic a0);
    logic [1:0] r;
    if (!is_byte) begin
      r = 2'b11;
    end else if (a0) begin
      r = 2'b10;
    end else begin
      r = 2'b01;
    end
    return r;
  endfunction

  // Final-access address: the fetched pointer for indirect ops, else the EX address.
  assign fin_addr_cur_s = ind_q ? ptr_q : addr_q;
  assign fin_addr_nxt_s = ind_d ? ptr_d : addr_d;

  // Next state and operand latching.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    byte_d  = byte_q;
    write_d = write_q;
    ind_d   = ind_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (in_valid && (mem_read || mem_write)) begin
          addr_d  = mem_address;
          wdata_d = mem_wdata;
          byte_d  = mem_byte;
          write_d = mem_write;
          ind_d   = mem_indirect;
          state_d = mem_indirect ? PTR : FINAL;
        end else begin
          state_d = IDLE;
        end
      end
      PTR: begin
        if (dmem_resp) begin
          ptr_d   = dmem_rdata;
          state_d = FINAL;
        end else begin
          state_d = PTR;
        end
      end
      FINAL: begin
        if (dmem_resp) begin
          if (!write_q) begin
            rdata_d = format_load(byte_q, fin_addr_cur_s[0], dmem_rdata);
          end else begin
            rdata_d = rdata_q;
          end
          state_d = DONE;
        end else begin
          state_d = FINAL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request outputs for the cycle after this edge, so dmem sees clean registered strobes.
  always_comb begin
    dmem_address_d = 16'h0000;
    dmem_wdata_d   = 16'h0000;
    dmem_read_d    = 1'b0;
    dmem_write_d   = 1'b0;
    dmem_be_d      = 2'b00;
    done_d         = 1'b0;
    case (state_d)
      PTR: begin
        dmem_read_d    = 1'b1;
        dmem_address_d = {addr_d[15:1], 1'b0};
        dmem_be_d      = 2'b11;
      end
      FINAL: begin
        dmem_write_d = write_d;
        dmem_read_d  = ~write_d;
        dmem_be_d    = lane_enable(byte_d, fin_addr_nxt_s[0]);
        if (byte_d) begin
          dmem_address_d = fin_addr_nxt_s;
          dmem_wdata_d   = {wdata_d[7:0], wdata_d[7:0]};
        end else begin
          dmem_address_d = {fin_addr_nxt_s[15:1], 1'b0};
          dmem_wdata_d   = wdata_d;
        end
      end
      DONE:    done_d = 1'b1;
      IDLE:    done_d = 1'b0;
      default: done_d = 1'b0;
    endcase
  end

  // Stall: immediate in IDLE so the requesting instruction freezes in its first cycle.
  always_comb begin
    case (state_q)
      IDLE:    mem_stall = in_valid & (mem_read | mem_write);
      PTR:     mem_stall = 1'b1;
      FINAL:   mem_stall = 1'b1;
      DONE:    mem_stall = 1'b0;
      default: mem_stall = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= 16'h0000;
      wdata_q        <= 16'h0000;
      byte_q         <= 1'b0;
      write_q        <= 1'b0;
      ind_q          <= 1'b0;
      ptr_q          <= 16'h0000;
      rdata_q        <= 16'h0000;
      done_q         <= 1'b0;
      dmem_address_q <= 16'h0000;
      dmem_wdata_q   <= 16'h0000;
      dmem_read_q    <= 1'b0;
      dmem_write_q   <= 1'b0;
      dmem_be_q      <= 2'b00;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      byte_q         <= byte_d;
      write_q        <= write_d;
      ind_q          <= ind_d;
      ptr_q          <= ptr_d;
      rdata_q        <= rdata_d;
      done_q         <= done_d;
      dmem_address_q <= dmem_address_d;
      dmem_wdata_q   <= dmem_wdata_d;
      dmem_read_q    <= dmem_read_d;
      dmem_write_q   <= dmem_write_d;
      dmem_be_q      <= dmem_be_d;
    end
  end

  assign dmem_address     = dmem_address_q;
  assign dmem_wdata       = dmem_wdata_q;
  assign dmem_read        = dmem_read_q;
  assign dmem_write       = dmem_write_q;
  assign dmem_byte_enable = dmem_be_q;
  assign mem_rdata_out    = rdata_q;
  assign mem_done         = done_q;

`ifdef MEM_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    if (mem_stall && (stall_cnt_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= {STALL_CNT_WIDTH{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_unused;
  assign stall_cnt_unused = {STALL_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a latency-programmable dmem model checks each request
// against expected accesses and compares formatted load data when mem_done fires.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, mem_read, mem_write, mem_byte, mem_indirect;
  logic [15:0] mem_address, mem_wdata;
  logic [15:0] dmem_address, dmem_wdata;
  logic        dmem_read, dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        mem_stall;
  logic [15:0] mem_rdata_out;
  logic        mem_done;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  mem_access_ctrl #(.STALL_CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte(mem_byte), .mem_indirect(mem_indirect),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_rdata_out(mem_rdata_out), .mem_done(mem_done)
`ifdef MEM_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } acc_t;

  acc_t        exp_acc[$];
  logic [15:0] exp_load[$];
  logic [15:0] rdq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_stall_total = 0;
  logic [15:0] last_load = 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic bt, input logic ind,
                       input logic [15:0] addr, input logic [15:0] wdata, input int lat,
                       input logic [15:0] ptr_rd, input logic [15:0] fin_rd,
                       input logic [15:0] e_addr, input logic [1:0] e_be,
                       input logic [15:0] e_wdata, input logic [15:0] e_rdata);
    acc_t        a;
    int          cnt;
    int          stalls;
    int          exp_stalls;
    bit          done;
    bit          saw_rd;
    logic [15:0] v;
    if (ind) begin
      a.wr = 1'b0; a.addr = {addr[15:1], 1'b0}; a.be = 2'b11; a.wdata = 16'h0000;
      exp_acc.push_back(a);
      rdq.push_back(ptr_rd);
    end
    a.wr = wr; a.addr = e_addr; a.be = e_be; a.wdata = e_wdata;
    exp_acc.push_back(a);
    rdq.push_back(fin_rd);
    if (rd && !wr) exp_load.push_back(e_rdata);
    exp_stalls = 1 + (ind ? 2 * lat : lat);

    @(negedge clk);
    in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_byte = bt; mem_indirect = ind;
    mem_address = addr; mem_wdata = wdata;
    cnt = 0; stalls = 0; done = 1'b0; saw_rd = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (cyc == 1) begin
        // upstream values change under stall; the DUT must use its latched copies
        mem_address = ~addr; mem_wdata = ~wdata; mem_byte = ~bt; mem_indirect = ~ind;
      end
      if (mem_stall) stalls++;
      if (dmem_read && wr && !ind) saw_rd = 1'b1;
      if (mem_done) begin
        done = 1'b1;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_resp = 1'b0;
        check_eq("done_stall_low", {31'd0, mem_stall}, 32'd0);
        check_eq("done_strobes_low", {30'd0, dmem_read, dmem_write}, 32'd0);
        if (rd && !wr) begin
          if (exp_load.size() == 0) begin
            check_eq("load_queue_underflow", 32'd1, 32'd0);
          end else begin
            v = exp_load.pop_front();
            last_load = v;
            check_eq("load_data", {16'd0, mem_rdata_out}, {16'd0, v});
          end
        end else begin
          check_eq("rdata_hold", {16'd0, mem_rdata_out}, {16'd0, last_load});
        end
      end else if (dmem_read || dmem_write) begin
        cnt++;
        if (cnt >= lat) begin
          if (exp_acc.size() == 0 || rdq.size() == 0) begin
            check_eq("access_queue_underflow", 32'd1, 32'd0);
            dmem_rdata = 16'h0000;
          end else begin
            a = exp_acc.pop_front();
            check_eq("acc_write", {31'd0, dmem_write}, {31'd0, a.wr});
            check_eq("acc_read", {31'd0, dmem_read}, {31'd0, ~a.wr});
            check_eq("acc_addr", {16'd0, dmem_address}, {16'd0, a.addr});
            check_eq("acc_be", {30'd0, dmem_byte_enable}, {30'd0, a.be});
            if (a.wr) check_eq("acc_wdata", {16'd0, dmem_wdata}, {16'd0, a.wdata});
            dmem_rdata = rdq.pop_front();
          end
          dmem_resp = 1'b1;
          cnt = 0;
        end else begin
          dmem_resp = 1'b0;
        end
      end else begin
        dmem_resp = 1'b0;
        cnt = 0;
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      check_eq("done_timeout", 32'd0, 32'd1);
      in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_resp = 1'b0;
      exp_acc.delete(); exp_load.delete(); rdq.delete();
    end
    check_eq("stall_cycles", stalls, exp_stalls);
    if (wr && !ind) check_eq("no_read_on_write", {31'd0, saw_rd}, 32'd0);
    exp_stall_total += exp_stalls;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte = 1'b0;
    mem_indirect = 1'b0; mem_address = 16'h0000; mem_wdata = 16'h0000;
    dmem_resp = 1'b0; dmem_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    check_eq("rst_read", {31'd0, dmem_read}, 32'd0);
    check_eq("rst_write", {31'd0, dmem_write}, 32'd0);
    check_eq("rst_be", {30'd0, dmem_byte_enable}, 32'd0);
    check_eq("rst_addr", {16'd0, dmem_address}, 32'd0);
    check_eq("rst_wdata", {16'd0, dmem_wdata}, 32'd0);
    check_eq("rst_done", {31'd0, mem_done}, 32'd0);
    check_eq("rst_rdata", {16'd0, mem_rdata_out}, 32'd0);
    reset = 1'b0;

    //     rd    wr    byte  ind   addr      wdata     lat ptr       final     e_addr    be     e_wdata   e_rdata
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 1, 16'h0000, 16'hBEEF, 16'h3000, 2'b11, 16'h0000, 16'hBEEF);
    do_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h4005, 16'h0000, 2, 16'h0000, 16'hA17C, 16'h4005, 2'b10, 16'h0000, 16'h00A1);
    do_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h4004, 16'h0000, 1, 16'h0000, 16'hA17C, 16'h4004, 2'b01, 16'h0000, 16'h007C);
    do_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h2003, 16'h1234, 2, 16'h0000, 16'h0000, 16'h2003, 2'b10, 16'h3434, 16'h0000);
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h2007, 16'hCAFE, 1, 16'h0000, 16'h0000, 16'h2006, 2'b11, 16'hCAFE, 16'h0000);
    do_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h1000, 16'h0000, 3, 16'h5000, 16'h0042, 16'h5000, 2'b11, 16'h0000, 16'h0042);
    do_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h0101, 16'h5A5A, 2, 16'h6001, 16'h0000, 16'h6000, 2'b11, 16'h5A5A, 16'h0000);

    // non-memory instruction passes straight through
    @(negedge clk);
    in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("nomem_stall", {31'd0, mem_stall}, 32'd0);
      check_eq("nomem_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
`ifdef MEM_STALL_CNT_EN
    check_eq("stall_count", stall_count, exp_stall_total);
`endif

    // reset during the FINAL wait, then a stale response
    in_valid = 1'b1; mem_read = 1'b1; mem_byte = 1'b0; mem_indirect = 1'b0; mem_address = 16'h7777;
    repeat (3) @(negedge clk);
    #1;
    check_eq("pre_reset_read", {31'd0, dmem_read}, 32'd1);
    reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_reset_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    check_eq("post_reset_stall", {31'd0, mem_stall}, 32'd0);
    check_eq("post_reset_rdata", {16'd0, mem_rdata_out}, 32'd0);
    check_eq("post_reset_addr", {16'd0, dmem_address}, 32'd0);
`ifdef MEM_STALL_CNT_EN
    check_eq("post_reset_stall_count", stall_count, 32'd0);
`endif
    dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
    @(negedge clk);
    dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("late_resp_done", {31'd0, mem_done}, 32'd0);
      check_eq("late_resp_rdata", {16'd0, mem_rdata_out}, 32'd0);
      check_eq("late_resp_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
